// File: rtl/acc_fifo_pkg.sv
// Shared defaults for the accelerator-side FIFO bridge.
// DATA_W_DEFAULT matches the router data bus; DEPTH_DEFAULT is the
// per-FIFO entry count (power of 2, >= 2); PTR_W_DEFAULT is log2(depth).
package acc_fifo_pkg;

  localparam int DATA_W_DEFAULT = 128;
  localparam int DEPTH_DEFAULT  = 8;
  localparam int PTR_W_DEFAULT  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single synchronous FIFO with registered read data and registered flags.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   enable_i          gates all push/pop requests
//   flush_i           clears pointers and count (data outputs hold)
//   push_i/push_data_i  push request and write data
//   pop_i             pop request
//   pop_data_o        registered pop data (holds when no pop)
//   pop_valid_o       one-cycle strobe: pop_data_o was loaded
//   empty_o/full_o    registered flags, derived from next-state count
//   overflow_o        pulse: enabled push rejected because full
//   underflow_o       pulse: enabled pop rejected because empty
module sync_fifo
  import acc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int PTR_W  = PTR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              empty_q, full_q, valid_q;
  logic [DATA_W-1:0] data_q;
  logic              push_ok, pop_ok;

  // Acceptance uses the registered flags, so a push while full or a pop
  // while empty is rejected even if the other side acts in the same cycle
  // (no pass-through when full, no bypass when empty).
  always_comb begin
    push_ok = enable_i & push_i & ~full_q & ~flush_i;
    pop_ok  = enable_i & pop_i & ~empty_q & ~flush_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + ONE_PTR;
      if (pop_ok)  rptr_d = rptr_q + ONE_PTR;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count, flag and read-data state. Flags come from count_d so
  // they are exact in the cycle following any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_COUNT);
      valid_q <= pop_ok;
      if (pop_ok) data_q <= mem_q[rptr_q];
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  assign pop_data_o  = data_q;
  assign pop_valid_o = valid_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign overflow_o  = enable_i & push_i & full_q;
  assign underflow_o = enable_i & pop_i & empty_q;

endmodule

// File: rtl/acc_fifo_bridge.sv
// Accelerator-side end of the router FIFO handshake.
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   enable                      accelerator enable; falling edge flushes
//   put_req/router_data_in      router push into to-accelerator FIFO
//   to_acc_empty/to_acc_full    to-accelerator FIFO flags
//   acc_rd_req                  accelerator pop of to-accelerator FIFO
//   acc_data_out/acc_data_valid registered pop data + one-cycle strobe
//   acc_wr_req/acc_data_in      accelerator push into from-accelerator FIFO
//   get_req                     router pop of from-accelerator FIFO
//   router_data_out/_valid      registered pop data + one-cycle strobe
//   from_acc_empty/_full        from-accelerator FIFO flags
//   overflow/underflow          sticky rejected push / rejected pop
module acc_fifo_bridge
  import acc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int PTR_W  = PTR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              put_req,
  input  logic [DATA_W-1:0] router_data_in,
  output logic              to_acc_empty,
  output logic              to_acc_full,
  input  logic              acc_rd_req,
  output logic [DATA_W-1:0] acc_data_out,
  output logic              acc_data_valid,
  input  logic              acc_wr_req,
  input  logic [DATA_W-1:0] acc_data_in,
  input  logic              get_req,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_data_valid,
  output logic              from_acc_empty,
  output logic              from_acc_full,
  output logic              overflow,
  output logic              underflow
);

  logic enable_q;
  logic flush;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic to_ovf, to_unf, from_ovf, from_unf;

  // The flush fires on the first edge that sees enable low after it was high.
  assign flush = enable_q & ~enable;

  always_comb begin
    overflow_d  = overflow_q | to_ovf | from_ovf;
    underflow_d = underflow_q | to_unf | from_unf;
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Enable history and sticky error bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      enable_q    <= enable;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_to_acc (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable),
    .flush_i     (flush),
    .push_i      (put_req),
    .push_data_i (router_data_in),
    .pop_i       (acc_rd_req),
    .pop_data_o  (acc_data_out),
    .pop_valid_o (acc_data_valid),
    .empty_o     (to_acc_empty),
    .full_o      (to_acc_full),
    .overflow_o  (to_ovf),
    .underflow_o (to_unf)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_from_acc (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable),
    .flush_i     (flush),
    .push_i      (acc_wr_req),
    .push_data_i (acc_data_in),
    .pop_i       (get_req),
    .pop_data_o  (router_data_out),
    .pop_valid_o (router_data_valid),
    .empty_o     (from_acc_empty),
    .full_o      (from_acc_full),
    .overflow_o  (from_ovf),
    .underflow_o (from_unf)
  );

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_acc_fifo_bridge.sv
// Self-checking bench for acc_fifo_bridge: directed stimulus pushes expected
// pop data into scoreboard queues; a monitor compares on each valid strobe.
module tb_acc_fifo_bridge;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          put_req;
  logic [DW-1:0] router_data_in;
  logic          to_acc_empty, to_acc_full;
  logic          acc_rd_req;
  logic [DW-1:0] acc_data_out;
  logic          acc_data_valid;
  logic          acc_wr_req;
  logic [DW-1:0] acc_data_in;
  logic          get_req;
  logic [DW-1:0] router_data_out;
  logic          router_data_valid;
  logic          from_acc_empty, from_acc_full;
  logic          overflow, underflow;

  int checkCount = 0;
  int failCount  = 0;

  logic [DW-1:0] expAcc[$];
  logic [DW-1:0] expRouter[$];

  acc_fifo_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .put_req           (put_req),
    .router_data_in    (router_data_in),
    .to_acc_empty      (to_acc_empty),
    .to_acc_full       (to_acc_full),
    .acc_rd_req        (acc_rd_req),
    .acc_data_out      (acc_data_out),
    .acc_data_valid    (acc_data_valid),
    .acc_wr_req        (acc_wr_req),
    .acc_data_in       (acc_data_in),
    .get_req           (get_req),
    .router_data_out   (router_data_out),
    .router_data_valid (router_data_valid),
    .from_acc_empty    (from_acc_empty),
    .from_acc_full     (from_acc_full),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of requests, let the edge happen, then release requests.
  task automatic applyStimulus(input logic put, input logic [DW-1:0] pdata,
                               input logic rd, input logic wr,
                               input logic [DW-1:0] wdata, input logic get);
    put_req        = put;
    router_data_in = pdata;
    acc_rd_req     = rd;
    acc_wr_req     = wr;
    acc_data_in    = wdata;
    get_req        = get;
    @(posedge clk);
    #1;
    put_req    = 1'b0;
    acc_rd_req = 1'b0;
    acc_wr_req = 1'b0;
    get_req    = 1'b0;
  endtask

  // Monitor: on the falling edge compare each valid strobe against the
  // oldest expected value; a strobe with nothing expected is a failure.
  initial begin
    forever begin
      @(negedge clk);
      if (acc_data_valid === 1'b1) begin
        if (expAcc.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL acc_unexpected_valid: got data %0h, expected no valid", acc_data_out);
        end else begin
          checkOutput("acc_data_out", acc_data_out, expAcc.pop_front());
        end
      end
      if (router_data_valid === 1'b1) begin
        if (expRouter.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL router_unexpected_valid: got data %0h, expected no valid", router_data_out);
        end else begin
          checkOutput("router_data_out", router_data_out, expRouter.pop_front());
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset = 1'b1; enable = 1'b0;
    put_req = 1'b0; acc_rd_req = 1'b0; acc_wr_req = 1'b0; get_req = 1'b0;
    router_data_in = '0; acc_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_to_acc_empty", to_acc_empty, 1);
    checkOutput("rst_from_acc_empty", from_acc_empty, 1);
    checkOutput("rst_to_acc_full", to_acc_full, 0);
    checkOutput("rst_acc_data_out", acc_data_out, 0);
    checkOutput("rst_router_valid", router_data_valid, 0);
    reset = 1'b0;
    enable = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_to_acc_empty", to_acc_empty, 1);
    checkOutput("idle_from_acc_empty", from_acc_empty, 1);
    checkOutput("idle_from_acc_full", from_acc_full, 0);
    checkOutput("idle_overflow", overflow, 0);
    checkOutput("idle_underflow", underflow, 0);

    // Fill to-accelerator FIFO with 1..8, then overflow with 9.
    for (int i = 1; i <= 8; i++) applyStimulus(1, DW'(i), 0, 0, 0, 0);
    checkOutput("fill_to_acc_full", to_acc_full, 1);
    checkOutput("fill_to_acc_empty", to_acc_empty, 0);
    applyStimulus(1, DW'(9), 0, 0, 0, 0);
    checkOutput("ovf_overflow", overflow, 1);
    checkOutput("ovf_to_acc_full", to_acc_full, 1);
    for (int i = 1; i <= 8; i++) begin
      expAcc.push_back(DW'(i));
      applyStimulus(0, 0, 1, 0, 0, 0);
    end
    checkOutput("drain_to_acc_empty", to_acc_empty, 1);
    checkOutput("drain_underflow", underflow, 0);

    // Drop and restore enable to clear the sticky overflow.
    enable = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flush1_overflow", overflow, 0);
    enable = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Wrap-around: push 5, pop 5, push 6, pop 6.
    for (int i = 0; i < 5; i++) applyStimulus(1, DW'(8'hA0 + i), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      expAcc.push_back(DW'(8'hA0 + i));
      applyStimulus(0, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1, DW'(8'hA0 + i), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      expAcc.push_back(DW'(8'hA0 + i));
      applyStimulus(0, 0, 1, 0, 0, 0);
    end
    checkOutput("wrap_overflow", overflow, 0);
    checkOutput("wrap_underflow", underflow, 0);
    checkOutput("wrap_to_acc_empty", to_acc_empty, 1);

    // Simultaneous push and pop with one entry stored.
    applyStimulus(1, DW'(8'h11), 0, 0, 0, 0);
    expAcc.push_back(DW'(8'h11));
    applyStimulus(1, DW'(8'h22), 1, 0, 0, 0);
    checkOutput("simul_to_acc_empty", to_acc_empty, 0);
    expAcc.push_back(DW'(8'h22));
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("simul_drain_empty", to_acc_empty, 1);

    // From-accelerator empty: push and pop together, pop is rejected.
    applyStimulus(0, 0, 0, 1, DW'(8'h55), 1);
    checkOutput("empty_underflow", underflow, 1);
    checkOutput("empty_router_valid", router_data_valid, 0);
    checkOutput("empty_from_acc_empty", from_acc_empty, 0);
    expRouter.push_back(DW'(8'h55));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("empty_from_acc_drained", from_acc_empty, 1);

    // From-accelerator full: push and pop together, push is rejected.
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, DW'(8'hB0 + i), 0);
    checkOutput("full_from_acc_full", from_acc_full, 1);
    checkOutput("full_overflow_before", overflow, 0);
    expRouter.push_back(DW'(8'hB0));
    applyStimulus(0, 0, 0, 1, DW'(8'hEE), 1);
    checkOutput("full_overflow", overflow, 1);
    checkOutput("full_from_acc_full_after", from_acc_full, 0);
    for (int i = 1; i < 8; i++) begin
      expRouter.push_back(DW'(8'hB0 + i));
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    checkOutput("full_drain_empty", from_acc_empty, 1);

    // Store 3 entries, then drop enable: everything flushes.
    for (int i = 0; i < 3; i++) applyStimulus(1, DW'(8'hC0 + i), 0, 1, DW'(8'hD0 + i), 0);
    enable = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("dis_to_acc_empty", to_acc_empty, 1);
    checkOutput("dis_from_acc_empty", from_acc_empty, 1);
    checkOutput("dis_overflow", overflow, 0);
    checkOutput("dis_underflow", underflow, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("dis_router_valid", router_data_valid, 0);
    checkOutput("dis_underflow_get", underflow, 0);
    checkOutput("dis_acc_data_hold", acc_data_out, DW'(8'h22));
    enable = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("reen_acc_valid", acc_data_valid, 0);
    checkOutput("reen_underflow", underflow, 1);

    // Reset mid-transfer discards stored data at once.
    applyStimulus(1, DW'(8'h77), 0, 0, 0, 0);
    applyStimulus(1, DW'(8'h78), 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    checkOutput("midrst_to_acc_empty", to_acc_empty, 1);
    checkOutput("midrst_acc_data_out", acc_data_out, 0);
    checkOutput("midrst_underflow", underflow, 0);
    reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_acc_left", DW'(expAcc.size()), 0);
    checkOutput("sb_router_left", DW'(expRouter.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
